// File: rtl/booth_r4_if.sv
// Operand/result handshake bundle for the iterative radix-4 Booth multiplier.
// The slave side is the multiplier; the master side feeds operands and drains results.
interface booth_r4_if #(
   parameter int WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [1:0]         fmt;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] result;
   logic               busy;

   modport master (
      output in_valid, a, b, fmt, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, b, fmt, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/booth_r4_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, unsigned / two's-complement /
// sign-magnitude formats, registered result held until the consumer takes it.
module booth_r4_seq #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   booth_r4_if.slave   bus
);
   localparam int EW = WIDTH + 2;
   localparam int AW = 2 * EW;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t             state_r;
   logic [EW-1:0]      mcand_r;
   logic [EW:0]        mplier_r;
   logic [AW-1:0]      acc_r;
   logic [CW-1:0]      cnt_r;
   logic               sm_r;
   logic [2*WIDTH-1:0] result_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               busy_r;

   logic [EW-1:0]      sel_s;
   logic [EW-1:0]      sum_hi_s;
   logic [AW-1:0]      acc_next_s;
   logic [EW:0]        mplier_next_s;

   // Operand to (WIDTH+2)-bit two's complement; the two guard bits keep +/-2X in range.
   function automatic logic [EW-1:0] to_ext(input logic [WIDTH-1:0] v, input logic [1:0] f);
      logic [WIDTH-1:0] mag;
      logic [WIDTH-1:0] tc;
      mag = {1'b0, v[WIDTH-2:0]};
      tc  = v[WIDTH-1] ? -mag : mag;
      case (f)
         2'b01:   to_ext = {{2{v[WIDTH-1]}}, v};
         2'b10:   to_ext = {{2{tc[WIDTH-1]}}, tc};
         default: to_ext = {2'b00, v};
      endcase
   endfunction

   // Product to output format; a non-negative product already has sign bit 0, so zero stays +0.
   function automatic logic [2*WIDTH-1:0] to_out(input logic [2*WIDTH-1:0] p, input logic sm);
      logic [2*WIDTH-1:0] mag;
      mag = -p;
      if (sm && p[2*WIDTH-1]) begin
         to_out = {1'b1, mag[2*WIDTH-2:0]};
      end else begin
         to_out = p;
      end
   endfunction

   // Booth digit decode and one add/shift step of the accumulator and multiplier.
   always_comb begin
      sel_s = {EW{1'b0}};
      case (mplier_r[2:0])
         3'b001, 3'b010: sel_s = mcand_r;
         3'b011:         sel_s = {mcand_r[EW-2:0], 1'b0};
         3'b100:         sel_s = -{mcand_r[EW-2:0], 1'b0};
         3'b101, 3'b110: sel_s = -mcand_r;
         default:        sel_s = {EW{1'b0}};
      endcase
      sum_hi_s      = acc_r[AW-1:EW] + sel_s;
      acc_next_s    = $signed({sum_hi_s, acc_r[EW-1:0]}) >>> 2'd2;
      mplier_next_s = $signed(mplier_r) >>> 2'd2;
   end

   // Control FSM together with the datapath registers and the registered port outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mcand_r     <= {EW{1'b0}};
         mplier_r    <= {(EW+1){1'b0}};
         acc_r       <= {AW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         sm_r        <= 1'b0;
         result_r    <= {(2*WIDTH){1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  mcand_r    <= to_ext(bus.a, bus.fmt);
                  mplier_r   <= {to_ext(bus.b, bus.fmt), 1'b0};
                  sm_r       <= (bus.fmt == 2'b10);
                  acc_r      <= {AW{1'b0}};
                  cnt_r      <= {CW{1'b0}};
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= CALC;
               end
            end
            CALC: begin
               acc_r    <= acc_next_s;
               mplier_r <= mplier_next_s;
               cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == CW'(N - 1)) begin
                  state_r <= FIN;
               end
            end
            FIN: begin
               // After N shifts of two the full signed product sits in the low accumulator half.
               result_r    <= to_out(acc_r[2*WIDTH-1:0], sm_r);
               out_valid_r <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.busy      = busy_r;
endmodule

// File: doc/booth_r4_seq.md
# booth_r4_seq

Parametrised, iterative radix-4 Booth multiplier with a valid/ready handshake on both sides. Each accepted operand pair is multiplied in one of three run-time number formats: unsigned, two's-complement signed, or sign-magnitude. The block retires one Booth digit (2 multiplier bits) per clock. It replaces the fully combinational Wallace-tree multiplier wherever area matters more than throughput, and feeds the arithmetic units behind a registered, back-pressurable result port.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥ 4; result is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair and mode present.
- `in_ready`  out  1  block idle and able to accept.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `fmt`  in  2  00 unsigned, 01 two's-complement signed, 10 sign-magnitude, 11 reserved (treated as 00).
- `out_valid`  out  1  `result` holds a finished product.
- `out_ready`  in  1  consumer takes `result`.
- `result`  out  2·WIDTH  product in the format selected by `fmt`.
- `busy`  out  1  high in CALC and FIN.

## Operation
- States: IDLE, CALC, FIN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `a`, `b`, `fmt`, clear the iteration counter, and go to CALC.
- Load conversion, done on the accepting edge:
  - Sign-magnitude operands convert to two's complement: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude. Negative zero becomes 0.
  - Both operands extend to WIDTH+2 bits: zero-extended for unsigned, sign-extended otherwise.
  - The multiplier gets an appended 0 below its LSB.
- CALC: N = WIDTH/2+1 iterations. Each iteration:
  - Decode the low 3 multiplier bits: 000/111 → 0, 001/010 → +X, 011 → +2X, 100 → −2X, 101/110 → −X.
  - Add the selected value into the upper half of a (2·WIDTH+4)-bit accumulator.
  - Arithmetic-shift accumulator and multiplier right by 2.
  - After iteration N, go to FIN.
- FIN, one cycle: take the low 2·WIDTH accumulator bits.
  - Unsigned and two's complement: the low bits are the exact product.
  - Sign-magnitude: convert to sign-magnitude. Sign is bit 2·WIDTH-1 and magnitude is bits 2·WIDTH-2:0. A zero product always has sign 0.
  - Register the value into `result` and go to DONE.
- DONE: `out_valid`=1 and `result` is held stable. On `out_ready`, go to IDLE.
- `in_ready` is 0 in DONE. There is no accept in the same cycle as result retirement.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Changes to `a`, `b`, `fmt` after the accepting edge have no effect.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0. State IDLE. Counter and accumulator 0.
- Reset asserted in any state aborts the operation immediately. The in-flight product is discarded.
- Accept at edge e0 → `out_valid` high after edge e0+N+1 = e0+WIDTH/2+2. For WIDTH=32 that is 18 cycles; for WIDTH=8, 6 cycles.
- Retire at edge r (`out_valid`&&`out_ready`) → `out_valid`=0 and `in_ready`=1 after r.
- Earliest next accept is edge r+1. Peak throughput is one product per WIDTH/2+4 cycles.
- `result` changes only on the FIN→DONE edge and on reset.

## Test plan
- Unsigned, WIDTH=8: a=0xFF, b=0xFF, fmt=00 → `result`=0xFE01. `out_valid` rises exactly 6 edges after accept.
- Signed corner, WIDTH=8: a=0x80, b=0x80, fmt=01 → 0x4000. Also a=0x80, b=0x7F → 0xC080. Also a=0xFF, b=0x01 → 0xFFFF.
- Sign-magnitude, WIDTH=8:
  - a=0x85 (−5), b=0x03 → 0x800F.
  - a=0x80 (−0), b=0x05 → 0x0000.
  - a=0xFF (−127), b=0xFF (−127) → 0x3F01.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE with new operands on `in_valid` → `result` stable, `in_ready`=0, no accept. After the handshake, `in_ready`=1 next cycle and the queued pair is accepted.
- Reset mid-CALC (iteration 2, WIDTH=32): drop `rst_n` → outputs return to reset values asynchronously. After release, a fresh 0x0000_0003 × 0xFFFF_FFFF, fmt=01 → 0xFFFF_FFFF_FFFF_FFFD at the 18-cycle latency.
- Randomised regression: 10k pairs over all fmt values, WIDTH=32 and WIDTH=4, compared against a reference model. Includes fmt=11 checked as unsigned.
